mul_unit: RTL and testbench
===========================

Name: mul_unit

Overview:
- Iterative multi-cycle multiply/accumulate execution unit. Sits directly downstream of the instruction decoder.
- Consumes the decoder's ALU control code for MUL, MLA and MLS, plus the register operands.
- Produces a 32-bit result and N/Z flags for writeback and condition logic.
- Drives a stall signal that freezes fetch/PC while the multiply is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- ALUControl  input  4  operation code: 4'b0110 MUL, 4'b0111 MLA, 4'b0101 MLS.
- SrcA  input  WIDTH  multiplicand (Rn).
- SrcB  input  WIDTH  multiplier (Rm).
- SrcC  input  WIDTH  accumulate operand (Ra); ignored for MUL.
- Result  output  WIDTH  low WIDTH bits of the final result; registered.
- Flags  output  2  {N,Z} of Result; registered.
- done  output  1  one-cycle pulse; Result and Flags are valid.
- busy  output  1  high in every state except IDLE.
- stall  output  1  combinational: (state==IDLE & start & valid op) | state==CALC | state==ACC.

Behaviour:
- Reset (synchronous, wins over every other input):
  - state=IDLE; Result=0, Flags=2'b00, done=0, busy=0.
  - Internal accumulator, multiplicand, multiplier and counter all clear.
  - A reset mid-operation abandons the operation; no done pulse follows.
- States: IDLE, CALC, ACC, DONE.
- IDLE:
  - Valid op = ALUControl in {0110, 0111, 0101}.
  - On start=1 with a valid op: latch SrcA, SrcB, SrcC and the op; clear the product accumulator; counter=0; next state CALC.
  - start=1 with any other code is ignored: stay in IDLE, no stall, no done.
- CALC: radix-2 shift-add, one multiplier bit per cycle, LSB first.
  - If the multiplier LSB is 1: product += multiplicand.
  - Then multiplicand <<= 1 and multiplier >>= 1.
  - Only the low WIDTH bits are kept; overflow is discarded (ARM low-word semantics).
  - Counter increments every cycle; when counter==WIDTH-1 the next state is ACC. This gives exactly WIDTH CALC cycles.
- ACC, one cycle, computed modulo 2^WIDTH:
  - MUL: Result=product.
  - MLA: Result=product+C.
  - MLS: Result=C-product.
  - N=Result[WIDTH-1]; Z=(Result==0). Result and Flags register at the end of ACC. Next state DONE.
- DONE, one cycle: done=1, busy=1, stall=0; next state IDLE.
  - A start during DONE is ignored; the requester re-asserts start in IDLE.
- Latency: start sampled at edge N → CALC during cycles N+1..N+WIDTH → ACC at N+WIDTH+1 → done high during cycle N+WIDTH+2 (N+34 for WIDTH=32) → IDLE at N+WIDTH+3.
- Result/Flags hold their last values until the next ACC or a reset.
- Input changes after start is accepted have no effect: operands are latched.
- Signed and unsigned operands give identical low-word results; no sign handling is needed.
- No C or V flag output. Flag-write gating (FlagW) is done by the consumer.

Test Plan:
- MUL: SrcA=7, SrcB=6, start 1 cycle → stall high from the start cycle through ACC; done exactly 34 cycles after the start edge; Result=42, Flags=2'b00.
- MLA wrap: SrcA=0xFFFFFFFF, SrcB=2, SrcC=3 → Result=0x00000001, Flags=00. Also SrcA=0x80000000, SrcB=1, SrcC=0 → Result=0x80000000, Flags=2'b10 (N set).
- MLS zero: SrcA=5, SrcB=4, SrcC=20 → Result=0, Flags=2'b01. Also SrcC=0 → Result=0xFFFFFFEC, Flags=2'b10.
- Invalid op/ignored start:
  - start with ALUControl=4'b0000 → busy, stall and done stay 0 for 40 cycles.
  - start pulsed during CALC/DONE and operands changed mid-CALC → single done; result of the original operands.
- Reset mid-op: reset at cycle 10 of CALC → next cycle state IDLE, busy=0, Result=0, no done pulse. A new MUL 3×3 then completes with Result=9.
- Back-to-back: start re-asserted in the IDLE cycle after DONE (MUL 0x10000×0x10000) → second done 34 cycles later, Result=0, Flags=2'b01.

Source files
------------

// File: rtl/mul_unit_if.sv
// rtl/mul_unit_if.sv - request/response bundle between the decoder side and mul_unit
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] SrcC;
  logic [WIDTH-1:0] Result;
  logic [1:0]       Flags;
  logic             done;
  logic             busy;
  logic             stall;

  modport master (
    output start, ALUControl, SrcA, SrcB, SrcC,
    input  Result, Flags, done, busy, stall
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB, SrcC,
    output Result, Flags, done, busy, stall
  );
endinterface

// File: rtl/mul_unit.sv
// rtl/mul_unit.sv - iterative radix-2 shift-add MUL/MLA/MLS unit with N/Z flags
module mul_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  mul_unit_if.slave  bus
);
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_MLA = 4'b0111;
  localparam logic [3:0] OP_MLS = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_res;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       flags_q;
  logic [3:0]       op;
  logic [CNT_W-1:0] cnt;
  logic             valid_op;
  logic             accept;
  logic             last_iter;

  assign valid_op  = (bus.ALUControl == OP_MUL) ||
                     (bus.ALUControl == OP_MLA) ||
                     (bus.ALUControl == OP_MLS);
  assign accept    = (state == IDLE) && bus.start && valid_op;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (last_iter) next_state = ACC;
      ACC:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // All arithmetic wraps modulo 2^WIDTH, so signed and unsigned operands agree.
  always_comb begin
    acc_res = prod;
    case (op)
      OP_MLA:  acc_res = prod + addend;
      OP_MLS:  acc_res = addend - prod;
      default: acc_res = prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      addend   <= '0;
      op       <= '0;
      cnt      <= '0;
      result_q <= '0;
      flags_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= bus.SrcA;
            mplier <= bus.SrcB;
            addend <= bus.SrcC;
            op     <= bus.ALUControl;
            prod   <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            prod <= prod + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        ACC: begin
          result_q <= acc_res;
          flags_q  <= {acc_res[WIDTH-1], (acc_res == '0)};
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Result = result_q;
  assign bus.Flags  = flags_q;
  assign bus.done   = (state == DONE);
  assign bus.busy   = (state != IDLE);
  assign bus.stall  = accept || (state == CALC) || (state == ACC);
endmodule

// File: tb/tb_mul_unit.sv
// tb/tb_mul_unit.sv - randomized self-checking bench for mul_unit against a cycle-count reference model
module tb_mul_unit;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_MLA = 4'b0111;
  localparam logic [3:0] OP_MLS = 4'b0101;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   edge_cnt = 0;

  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic [1:0]  m_flags = 2'b00;

  mul_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic is_valid(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MLA) || (op == OP_MLS);
  endfunction

  function automatic logic [31:0] ref_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
    logic [31:0] p;
    p = a * b;
    if (op == OP_MLA) return p + c;
    if (op == OP_MLS) return c - p;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Model: an accepted op occupies WIDTH CALC cycles + ACC + DONE; result appears with DONE.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (reset) begin
      m_left  <= 0;
      m_res   <= '0;
      m_flags <= 2'b00;
    end else if (m_left == 0) begin
      if (bus.start && is_valid(bus.ALUControl)) begin
        m_left <= WIDTH + 2;
        m_pend <= ref_calc(bus.ALUControl, bus.SrcA, bus.SrcB, bus.SrcC);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res   <= m_pend;
        m_flags <= {m_pend[31], (m_pend == 32'd0)};
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   32'(bus.busy),  32'(m_left != 0));
      chk("done",   32'(bus.done),  32'(m_left == 1));
      chk("stall",  32'(bus.stall), 32'((m_left >= 2) ||
                                        ((m_left == 0) && bus.start && is_valid(bus.ALUControl))));
      chk("Result", bus.Result, m_res);
      chk("Flags",  32'(bus.Flags), 32'(m_flags));
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [31:0] exp_res, input logic [1:0] exp_flags, input bit noise);
    int  s;
    bit  got;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.ALUControl = op;
    bus.SrcA = a;
    bus.SrcB = b;
    bus.SrcC = c;
    s = edge_cnt + 1;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (noise) begin
        bus.start = 1'($urandom);
        bus.ALUControl = 4'($urandom);
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        bus.SrcC = $urandom;
        if (edge_cnt == s + 33) begin
          bus.start = 1'b1;
          bus.ALUControl = OP_MUL;
        end
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_done_cycle"}, 32'(edge_cnt + 1 - s), 32'd34);
      chk({name, "_result"}, bus.Result, exp_res);
      chk({name, "_flags"}, 32'(bus.Flags), 32'(exp_flags));
    end
  endtask

  initial begin
    int s;
    int seen;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] r;
    bus.start = 1'b0;
    bus.ALUControl = 4'b0000;
    bus.SrcA = '0;
    bus.SrcB = '0;
    bus.SrcC = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.Result, 32'd0);
    chk("rst_flags", 32'(bus.Flags), 32'd0);

    run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'd0, 32'd42, 2'b00, 1'b0);
    run_op("mla_wrap", OP_MLA, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'h0000_0001, 2'b00, 1'b0);
    run_op("mla_neg", OP_MLA, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 2'b10, 1'b0);
    run_op("mls_zero", OP_MLS, 32'd5, 32'd4, 32'd20, 32'd0, 2'b01, 1'b0);
    run_op("mls_neg", OP_MLS, 32'd5, 32'd4, 32'd0, 32'hFFFF_FFEC, 2'b10, 1'b0);

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.ALUControl = 4'b0000;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy || bus.stall || bus.done) seen++;
    end
    chk("invalid_quiet", 32'(seen), 32'd0);

    run_op("ignored_start", OP_MUL, 32'd11, 32'd13, 32'd0, 32'd143, 2'b00, 1'b1);

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.ALUControl = OP_MUL;
    bus.SrcA = 32'd1234;
    bus.SrcB = 32'd5678;
    s = edge_cnt + 1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (edge_cnt < s + 10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_result", bus.Result, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    run_op("mul_3x3", OP_MUL, 32'd3, 32'd3, 32'd0, 32'd9, 2'b00, 1'b0);
    run_op("b2b_wrap", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 2'b01, 1'b0);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: op = OP_MUL;
        1: op = OP_MLA;
        2: op = OP_MLS;
        default: op = 4'($urandom);
      endcase
      a = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (i % 7 == 0) ? 32'd0 : $urandom;
      c = $urandom;
      if (is_valid(op)) begin
        r = ref_calc(op, a, b, c);
        run_op("rand", op, a, b, c, r, {r[31], (r == 32'd0)}, 1'(i % 2));
      end else begin
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.ALUControl = op;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
